fc_score_layer: RTL and testbench

//  Sequential fully-connected output layer that sits directly upstream of the class-index (argmax) stage.
//  - Consumes one activation per beat, together with that beat's N weights.
//  - Accumulates N dot products of length M in parallel and adds a per-class bias.
//  - Rescales and clamps each sum into unsigned WIDTH-bit scores.
//  - Emits the scores as one packed vector under a valid/ready handshake.

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/fc_score_layer_if.sv | 26 ++
 rtl/fc_mac_lane.sv | 32 +++
 rtl/fc_score_layer.sv | 97 +++++++++
 tb/tb_fc_score_layer.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN-layer types and helpers: FSM states, accumulator sizing, and the
// shift-then-clamp rescale into an unsigned score.
package cnn_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    OUT   = 2'd2
  } fc_state_e;

  localparam int unsigned SAT_W = 64;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned m);
    return 2 * dw + $clog2(m) + 2;
  endfunction

  // Arithmetic shift, then clamp to [0, 2^width-1]; caller truncates to width bits.
  function automatic logic [SAT_W-1:0] sat_unsigned(input logic signed [SAT_W-1:0] acc,
                                                    input int unsigned shift,
                                                    input int unsigned width);
    logic signed [SAT_W-1:0] y;
    logic [SAT_W-1:0]        max_v;
    y     = acc >>> shift;
    max_v = (SAT_W'(1) << width) - SAT_W'(1);
    if (y < 0) return '0;
    if ($unsigned(y) > max_v) return max_v;
    return $unsigned(y);
  endfunction

endpackage

// File: rtl/fc_score_layer_if.sv
// Beat-in / score-vector-out handshake bundle of the fully-connected score layer.
interface fc_score_layer_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned BW    = 16,
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_act;
  logic [N*DW-1:0]      in_w;
  logic [N*BW-1:0]      bias_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*WIDTH-1:0]   out_vec;

  modport master (
    output in_valid, in_act, in_w, bias_vec, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_act, in_w, bias_vec, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/fc_mac_lane.sv
// One signed multiply-accumulate lane; the first beat of a frame reloads the
// accumulator with the sign-extended bias instead of the previous sum.
module fc_mac_lane #(
  parameter int unsigned DW    = 8,
  parameter int unsigned BW    = 16,
  parameter int unsigned ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    first_i,
  input  logic signed [DW-1:0]    act_i,
  input  logic signed [DW-1:0]    w_i,
  input  logic signed [BW-1:0]    bias_i,
  output logic signed [ACC_W-1:0] acc_o
);
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    prod  = act_i * w_i;
    acc_d = (first_i ? ACC_W'(bias_i) : acc_q) + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/fc_score_layer.sv
// Sequential fully-connected output layer: N parallel MAC lanes over M beats,
// then shift/clamp into unsigned scores presented under valid/ready.
module fc_score_layer
  import cnn_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned BW    = 16,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  fc_score_layer_if.slave  bus
);
  localparam int unsigned     ACC_W = acc_width(DW, M);
  localparam int unsigned     CNT_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(M - 1);

  fc_state_e                state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [N*WIDTH-1:0]       out_vec_q;
  logic signed [ACC_W-1:0]  acc [N];
  logic [N*WIDTH-1:0]       score_c;
  logic                     in_fire_c;
  logic                     first_c;

  assign in_fire_c = bus.in_valid & in_ready_q;
  assign first_c   = (cnt_q == '0);

  for (genvar j = 0; j < N; j++) begin : g_lane
    fc_mac_lane #(.DW(DW), .BW(BW), .ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (in_fire_c),
      .first_i (first_c),
      .act_i   (bus.in_act),
      .w_i     (bus.in_w[j*DW +: DW]),
      .bias_i  (bus.bias_vec[j*BW +: BW]),
      .acc_o   (acc[j])
    );
  end

  always_comb begin
    score_c = '0;
    for (int j = 0; j < N; j++)
      score_c[j*WIDTH +: WIDTH] = WIDTH'(sat_unsigned(SAT_W'(acc[j]), SHIFT, WIDTH));
  end

  // in_ready is registered alongside the state so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_fire_c) begin
            if (cnt_q == LAST) begin
              cnt_q      <= '0;
              state_q    <= FINAL;
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        FINAL: begin
          out_vec_q   <= score_c;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
endmodule

// File: tb/tb_fc_score_layer.sv
// Directed bench for fc_score_layer with N=4, M=4, DW=8, BW=16, WIDTH=16, SHIFT=0.
module tb_fc_score_layer;
  localparam int unsigned N = 4, M = 4, DW = 8, BW = 16, WIDTH = 16, SHIFT = 0;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  fc_score_layer_if #(.N(N), .DW(DW), .BW(BW), .WIDTH(WIDTH)) bus ();

  fc_score_layer #(.N(N), .M(M), .DW(DW), .BW(BW), .WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Drives one frame of M identical beats; bias is junk after beat 0.
  task automatic run_frame(input string name, input logic [DW-1:0] act,
                           input logic [N*DW-1:0] w, input logic [N*BW-1:0] bias,
                           input bit gaps, input int hold, input logic [N*WIDTH-1:0] exp_vec);
    nvec++;
    if (bus.in_ready !== 1'b1) begin
      nerr++; $display("FAIL %s in_ready_at_start got %b want 1", name, bus.in_ready);
    end
    for (int k = 0; k < M; k++) begin
      if (gaps) repeat (1 + k % 3) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_act   = act;
      bus.in_w     = w;
      bus.bias_vec = (k == 0) ? bias : {N{16'h7ABC}};
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      nerr++; $display("FAIL %s final_cycle got valid=%b ready=%b want 0 0", name, bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    nvec++;
    if (bus.out_valid !== 1'b1) begin
      nerr++; $display("FAIL %s latency got out_valid=%b want 1", name, bus.out_valid);
    end
    nvec++;
    if (bus.out_vec !== exp_vec) begin
      nerr++; $display("FAIL %s out_vec got %h want %h", name, bus.out_vec, exp_vec);
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      nvec++;
      if (bus.out_valid !== 1'b1 || bus.out_vec !== exp_vec || bus.in_ready !== 1'b0) begin
        nerr++; $display("FAIL %s hold%0d got valid=%b vec=%h ready=%b want 1 %h 0",
                         name, c, bus.out_valid, bus.out_vec, bus.in_ready, exp_vec);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_vec !== exp_vec) begin
      nerr++; $display("FAIL %s after_handshake got valid=%b ready=%b vec=%h want 0 1 %h",
                       name, bus.out_valid, bus.in_ready, bus.out_vec, exp_vec);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_act = '0; bus.in_w = '0; bus.bias_vec = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_vec !== '0) begin
      nerr++; $display("FAIL reset got valid=%b ready=%b vec=%h want 0 1 0", bus.out_valid, bus.in_ready, bus.out_vec);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    run_frame("ramp", 8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, '0, 1'b0, 0,
              {16'd16, 16'd12, 16'd8, 16'd4});
  endtask

  task automatic test_clamp_low();
    run_frame("clamp_low", 8'h80, {8'd0, 8'd0, 8'd0, 8'd127}, '0, 1'b0, 0, '0);
  endtask

  task automatic test_clamp_high();
    run_frame("clamp_high", 8'd127, {8'd0, 8'd0, 8'd127, 8'd0},
              {16'd0, 16'd0, 16'd32767, 16'd0}, 1'b0, 0, {16'd0, 16'd0, 16'hFFFF, 16'd0});
  endtask

  // act=2: lane0 8-8=0, lane1 1000+800=1800, lane2 100-24=76, lane3 -50+40=-10 -> 0.
  task automatic test_mixed_bias();
    run_frame("mixed_bias", 8'd2, {8'd5, 8'hFD, 8'd100, 8'hFF},
              {16'hFFCE, 16'd100, 16'd1000, 16'd8}, 1'b0, 0,
              {16'd0, 16'd76, 16'd1800, 16'd0});
  endtask

  task automatic test_back_to_back();
    run_frame("stall", 8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, '0, 1'b0, 5,
              {16'd16, 16'd12, 16'd8, 16'd4});
    run_frame("next_frame", 8'd127, {8'd0, 8'd0, 8'd127, 8'd0},
              {16'd0, 16'd0, 16'd32767, 16'd0}, 1'b0, 0, {16'd0, 16'd0, 16'hFFFF, 16'd0});
  endtask

  task automatic test_gaps();
    run_frame("gaps", 8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, '0, 1'b1, 0,
              {16'd16, 16'd12, 16'd8, 16'd4});
  endtask

  task automatic test_midframe_reset();
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.in_act = 8'd5; bus.in_w = {4{8'd9}}; bus.bias_vec = {4{16'd300}};
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_vec !== '0) begin
      nerr++; $display("FAIL midreset_in_reset got valid=%b ready=%b vec=%h want 0 1 0",
                       bus.out_valid, bus.in_ready, bus.out_vec);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      nerr++; $display("FAIL midreset_release got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    run_frame("after_reset", 8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, '0, 1'b0, 0,
              {16'd16, 16'd12, 16'd8, 16'd4});
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_clamp_low();
    test_clamp_high();
    test_mixed_bias();
    test_back_to_back();
    test_gaps();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
